// File: rtl/match_sequencer.sv
// ---------------------------------------------------------------------------
// MatchSequencer: round/match controller for a two-player fighting game.
// Sequences IDLE -> COUNTDOWN -> FIGHT -> ROUND_END -> (COUNTDOWN | MATCH_END),
// tracks per-player health and shield, runs the round clock and keeps the
// round-win tally until one player has won the match.
//
// Ports
//   logic_clk              frame clock
//   reset                  asynchronous active-high reset
//   start                  begin / restart a match (IDLE and MATCH_END only)
//   p1_stunmode[1:0]       P1 stun code from player logic (01 hit, 10 block)
//   p2_stunmode[1:0]       P2 stun code
//   health1/2[2:0]         current health per player
//   shield1/2[2:0]         current shield per player
//   round_timer[6:0]       seconds left in the round
//   match_state[2:0]       current FSM state code
//   player_reset           one-cycle pulse on the first COUNTDOWN cycle
//   freeze                 1 whenever player inputs must be ignored
//   p1_rounds/p2_rounds    round wins per player
//   winner[1:0]            00 none, 01 P1, 10 P2, 11 draw
// ---------------------------------------------------------------------------
module match_sequencer #(
    parameter int START_HEALTH     = 3,
    parameter int START_SHIELD     = 3,
    parameter int ROUND_SECONDS    = 60,
    parameter int FRAMES_PER_SEC   = 60,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int ROUND_END_FRAMES = 120,
    parameter int ROUNDS_TO_WIN    = 2
) (
    input  logic       logic_clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] p1_stunmode,
    input  logic [1:0] p2_stunmode,
    output logic [2:0] health1,
    output logic [2:0] health2,
    output logic [2:0] shield1,
    output logic [2:0] shield2,
    output logic [6:0] round_timer,
    output logic [2:0] match_state,
    output logic       player_reset,
    output logic       freeze,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [1:0] winner
);

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_FIGHT     = 3'd2,
        S_ROUND_END = 3'd3,
        S_MATCH_END = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_health1, r_health2, r_shield1, r_shield2;
    logic [6:0]       r_timer;
    logic [1:0]       r_p1_rounds, r_p2_rounds, r_winner;
    logic [1:0]       r_prev1, r_prev2;
    logic             r_player_reset;

    logic             w_p1_hit, w_p1_block, w_p2_hit, w_p2_block;
    logic             w_fight_end, w_cd_done, w_re_done, w_match_done;
    logic             w_enter_cd, w_frame_wrap;
    logic [1:0]       w_round_result;

    // Edge detection on the stun codes plus the end-of-phase conditions.
    // The round is over as soon as a registered health or the timer is 0;
    // no further events are applied in that last FIGHT cycle.
    always_comb begin
        w_p1_hit     = (r_prev1 != 2'b01) && (p1_stunmode == 2'b01);
        w_p1_block   = (r_prev1 != 2'b10) && (p1_stunmode == 2'b10);
        w_p2_hit     = (r_prev2 != 2'b01) && (p2_stunmode == 2'b01);
        w_p2_block   = (r_prev2 != 2'b10) && (p2_stunmode == 2'b10);
        w_fight_end  = (r_health1 == 3'd0) || (r_health2 == 3'd0) || (r_timer == 7'd0);
        w_cd_done    = (r_cnt == CNT_W'(COUNTDOWN_FRAMES - 1));
        w_re_done    = (r_cnt == CNT_W'(ROUND_END_FRAMES - 1));
        w_frame_wrap = (r_cnt == CNT_W'(FRAMES_PER_SEC - 1));
        w_match_done = (int'(r_p1_rounds) >= ROUNDS_TO_WIN) ||
                       (int'(r_p2_rounds) >= ROUNDS_TO_WIN);
    end

    // Round result: knockouts take precedence, otherwise a timer expiry is
    // decided on remaining health.
    always_comb begin
        w_round_result = 2'b11;
        if (r_health1 == 3'd0 && r_health2 == 3'd0)
            w_round_result = 2'b11;
        else if (r_health1 == 3'd0)
            w_round_result = 2'b10;
        else if (r_health2 == 3'd0)
            w_round_result = 2'b01;
        else if (r_health1 > r_health2)
            w_round_result = 2'b01;
        else if (r_health2 > r_health1)
            w_round_result = 2'b10;
    end

    // Next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next_state = S_COUNTDOWN;
            S_COUNTDOWN: if (w_cd_done) w_next_state = S_FIGHT;
            S_FIGHT:     if (w_fight_end) w_next_state = S_ROUND_END;
            S_ROUND_END: if (w_re_done)
                             w_next_state = w_match_done ? S_MATCH_END : S_COUNTDOWN;
            S_MATCH_END: if (start) w_next_state = S_COUNTDOWN;
            default:     w_next_state = S_IDLE;
        endcase
        w_enter_cd = (r_state != S_COUNTDOWN) && (w_next_state == S_COUNTDOWN);
    end

    // State register.
    always_ff @(posedge logic_clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Datapath: phase counter, round clock, health/shield, tally and winner.
    // The stun history is cleared by reset so a code held across reset
    // release is seen as a fresh edge.
    always_ff @(posedge logic_clk or posedge reset) begin
        if (reset) begin
            r_cnt          <= '0;
            r_health1      <= 3'(START_HEALTH);
            r_health2      <= 3'(START_HEALTH);
            r_shield1      <= 3'(START_SHIELD);
            r_shield2      <= 3'(START_SHIELD);
            r_timer        <= 7'(ROUND_SECONDS);
            r_p1_rounds    <= 2'd0;
            r_p2_rounds    <= 2'd0;
            r_winner       <= 2'b00;
            r_prev1        <= 2'b00;
            r_prev2        <= 2'b00;
            r_player_reset <= 1'b1;
        end else begin
            r_prev1        <= p1_stunmode;
            r_prev2        <= p2_stunmode;
            r_player_reset <= w_enter_cd;

            if (w_next_state != r_state)
                r_cnt <= '0;
            else if (r_state == S_FIGHT)
                r_cnt <= w_frame_wrap ? '0 : r_cnt + CNT_W'(1);
            else if (r_state == S_COUNTDOWN || r_state == S_ROUND_END)
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;

            if (w_enter_cd) begin
                r_health1 <= 3'(START_HEALTH);
                r_health2 <= 3'(START_HEALTH);
                r_shield1 <= 3'(START_SHIELD);
                r_shield2 <= 3'(START_SHIELD);
                r_timer   <= 7'(ROUND_SECONDS);
                r_winner  <= 2'b00;
                if (r_state != S_ROUND_END) begin
                    r_p1_rounds <= 2'd0;
                    r_p2_rounds <= 2'd0;
                end
            end else if (r_state == S_FIGHT && !w_fight_end) begin
                if (w_p1_hit && r_health1 != 3'd0)   r_health1 <= r_health1 - 3'd1;
                if (w_p2_hit && r_health2 != 3'd0)   r_health2 <= r_health2 - 3'd1;
                if (w_p1_block && r_shield1 != 3'd0) r_shield1 <= r_shield1 - 3'd1;
                if (w_p2_block && r_shield2 != 3'd0) r_shield2 <= r_shield2 - 3'd1;
                if (w_frame_wrap && r_timer != 7'd0) r_timer <= r_timer - 7'd1;
            end else if (r_state == S_FIGHT) begin
                r_winner <= w_round_result;
                if (w_round_result == 2'b01 && r_p1_rounds != 2'd3)
                    r_p1_rounds <= r_p1_rounds + 2'd1;
                if (w_round_result == 2'b10 && r_p2_rounds != 2'd3)
                    r_p2_rounds <= r_p2_rounds + 2'd1;
            end else if (r_state == S_ROUND_END && w_re_done && w_match_done) begin
                r_winner <= (int'(r_p1_rounds) >= ROUNDS_TO_WIN) ? 2'b01 : 2'b10;
            end
        end
    end

    assign health1      = r_health1;
    assign health2      = r_health2;
    assign shield1      = r_shield1;
    assign shield2      = r_shield2;
    assign round_timer  = r_timer;
    assign match_state  = r_state;
    assign player_reset = r_player_reset;
    assign freeze       = (r_state != S_FIGHT);
    assign p1_rounds    = r_p1_rounds;
    assign p2_rounds    = r_p2_rounds;
    assign winner       = r_winner;

endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 SHALL provide parameter START_HEALTH, 3, health loaded per player at round start.
REQ-002 SHALL provide parameter START_SHIELD, 3, shield loaded per player at round start.
REQ-003 SHALL provide parameter ROUND_SECONDS, 60, round clock start value (max 127).
REQ-004 SHALL provide parameter FRAMES_PER_SEC, 60, logic_clk cycles per round-clock second.
REQ-005 SHALL provide parameter COUNTDOWN_FRAMES, 180, pre-fight freeze length in cycles.
REQ-006 SHALL provide parameter ROUND_END_FRAMES, 120, post-round freeze length in cycles.
REQ-007 SHALL provide parameter ROUNDS_TO_WIN, 2, round wins that end the match.
REQ-008 SHALL have ports: logic_clk in 1 frame clock; reset in 1 asynchronous active-high reset; start in 1 begin/restart match; p1_stunmode in 2 P1 stun code (01 hit, 10 block); p2_stunmode in 2 P2 stun code.
REQ-009 SHALL have outputs: health1, health2 out 3 each; shield1, shield2 out 3 each; round_timer out 7 seconds left; match_state out 3 FSM state; player_reset out 1 one-cycle player-controller reset; freeze out 1 disables player inputs; p1_rounds, p2_rounds out 2 each round wins; winner out 2 (00 none, 01 P1, 10 P2, 11 draw).

Function
REQ-010 SHALL implement states IDLE=0, COUNTDOWN=1, FIGHT=2, ROUND_END=3, MATCH_END=4; match_state equals current state.
REQ-011 IDLE: start=1 -> COUNTDOWN; p1_rounds, p2_rounds, winner cleared to 0 on that edge.
REQ-012 Entering COUNTDOWN: health/shield loaded with START values, round_timer=ROUND_SECONDS, phase counter=0, player_reset=1 for exactly the first COUNTDOWN cycle.
REQ-013 COUNTDOWN: after COUNTDOWN_FRAMES cycles -> FIGHT; stun inputs ignored.
REQ-014 freeze SHALL be 1 in every state except FIGHT.
REQ-015 Hit event: pN_stunmode registered previous value !=01 and current ==01; block event: previous !=10 and current ==10; level holds SHALL NOT re-trigger.
REQ-016 In FIGHT only, hit event SHALL decrement opponent-of-attacker's victim health (healthN for pN_stunmode) by 1 at next edge, saturating at 0.
REQ-017 In FIGHT only, block event SHALL decrement shieldN by 1 at next edge, saturating at 0; health unchanged.
REQ-018 Simultaneous P1 and P2 events in one cycle SHALL both apply in the same edge.
REQ-019 Round clock: frame counter 0..FRAMES_PER_SEC-1 in FIGHT; on wrap round_timer decrements by 1; never below 0.
REQ-020 FIGHT -> ROUND_END on the edge after any health reaches 0 or round_timer reaches 0.
REQ-021 Round result on FIGHT->ROUND_END edge: only health1==0 -> P2 wins; only health2==0 -> P1 wins; both 0 -> draw; timer expiry -> higher health wins, equal -> draw.
REQ-022 Round win SHALL increment corresponding pN_rounds (saturating at 3); draw increments neither; winner shows round result during ROUND_END.
REQ-023 ROUND_END: after ROUND_END_FRAMES cycles -> MATCH_END if either pN_rounds >= ROUNDS_TO_WIN, else COUNTDOWN with winner cleared.
REQ-024 MATCH_END: winner holds match winner (01/10); outputs frozen; start=1 -> COUNTDOWN with rounds and winner cleared.
REQ-025 start SHALL be ignored in COUNTDOWN, FIGHT, ROUND_END.
REQ-026 Unused state codes SHALL return to IDLE next edge.

Reset
REQ-027 reset=1 SHALL immediately force: state IDLE, health1/2=START_HEALTH, shield1/2=START_SHIELD, round_timer=ROUND_SECONDS, rounds=0, winner=00, player_reset=1, freeze=1, all counters 0.
REQ-028 Reset mid-FIGHT SHALL discard pending events; first edge after release samples stun history as 00.
REQ-029 player_reset SHALL be 0 in IDLE after reset release until next COUNTDOWN entry.

Verification
REQ-030 Reset, start=1 one cycle -> player_reset pulses 1 cycle, freeze=1 for 180 cycles, then match_state=2, freeze=0.
REQ-031 In FIGHT, p2_stunmode 00->01 held 10 cycles -> health2 3->2 once only; p1_stunmode 00->10 -> shield1 3->2, health1 stays 3.
REQ-032 Three P2 hits -> health2=0, next edge ROUND_END, winner=01, p1_rounds=1; 120 cycles later COUNTDOWN with health reset to 3.
REQ-033 Same-cycle hits with both health=1 -> both 0, winner=11, rounds unchanged.
REQ-034 No hits for 60*60 FIGHT cycles, health1=3, health2=2 -> round_timer=0, winner=01; second P1 round win -> MATCH_END, winner=01, start restarts.
REQ-035 Assert reset during FIGHT with health2=1 -> state IDLE, health2=3, rounds=0 same cycle.
